regfile_wr_arbiter: RTL and testbench



---
 rtl/regfile_wr_arbiter.sv | 142 ++++++++++++++
 tb/tb_regfile_wr_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - shares the register-file write port among N_REQ writeback requesters
// Define REGFILE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module regfile_wr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int ZERO_REG = 31,
  parameter int LOCK_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_lock,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      wr_stall,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [DATA_W-1:0]         wr_data,
  output logic [$clog2(N_REQ)-1:0]  grant_id,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [CW-1:0]   lock_cnt;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
  logic [IW-1:0]   rr_ptr;
  logic [2*N_REQ-1:0] rot;
  int              idx;
`endif

  logic              win_vld;
  logic [IW-1:0]     win;
  logic              owner_vld;
  logic              acc;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              win_lock;
  logic [IW-1:0]     win_next;

  always_comb begin
    win_vld   = 1'b0;
    win       = '0;
    owner_vld = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (owner == IW'(j)) owner_vld = req_valid[j];
    end
`ifndef REGFILE_ARB_FIXED_PRIO_EN
    rot = {req_valid, req_valid} >> rr_ptr;
    idx = 0;
`endif
    if (state == LOCKED) begin
      win_vld = owner_vld;
      win     = owner;
    end else begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (req_valid[k]) begin
          win_vld = 1'b1;
          win     = IW'(k);
        end
      end
`else
      // Descending scan so the candidate closest to rr_ptr is assigned last and wins.
      for (int k = N_REQ - 1; k >= 0; k--) begin
        if (rot[k]) begin
          idx     = (int'(rr_ptr) + k) % N_REQ;
          win_vld = 1'b1;
          win     = IW'(idx);
        end
      end
`endif
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    win_lock = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (win == IW'(j)) begin
        win_addr = req_addr[j*ADDR_W +: ADDR_W];
        win_data = req_data[j*DATA_W +: DATA_W];
        win_lock = req_lock[j];
      end
    end
  end

  assign acc       = win_vld & ~reset & ~wr_stall;
  assign req_ready = acc ? (N_REQ'(1) << win) : '0;
  assign win_next  = (win == IW'(N_REQ - 1)) ? '0 : win + IW'(1);
  assign busy      = (state == LOCKED) | wr_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      grant_id <= '0;
      state    <= IDLE;
      owner    <= '0;
      lock_cnt <= '0;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
      rr_ptr   <= '0;
`endif
    end else if (!wr_stall) begin
      if (acc) begin
        wr_en    <= (win_addr != ADDR_W'(ZERO_REG));
        wr_addr  <= win_addr;
        wr_data  <= win_data;
        grant_id <= win;
`ifndef REGFILE_ARB_FIXED_PRIO_EN
        // Owner is the only winner while locked, so this yields owner+1 on exit.
        rr_ptr   <= win_next;
`endif
        if (state == IDLE) begin
          if (win_lock && (LOCK_MAX > 1)) begin
            state    <= LOCKED;
            owner    <= win;
            lock_cnt <= CW'(1);
          end
        // lock_cnt counts beats already taken; the LOCK_MAX-th beat always releases.
        end else if (!win_lock || (lock_cnt >= CW'(LOCK_MAX - 1))) begin
          state    <= IDLE;
          lock_cnt <= '0;
        end else begin
          lock_cnt <= lock_cnt + CW'(1);
        end
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - table-driven directed bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

  localparam int N = 4, AW = 5, DW = 64;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_lock = '0;
  logic [N-1:0]    req_ready;
  logic            wr_stall = 1'b0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [1:0]      grant_id;
  logic            busy;

  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
    .wr_stall(wr_stall), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [3:0]  lck;
    logic        stl;
    logic [19:0] adr;
    logic [3:0]  rdy;
    logic        en;
    logic [4:0]  wa;
    logic [1:0]  gid;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [19:0] ADR_A = {5'd4, 5'd3, 5'd2, 5'd1};
  localparam logic [19:0] ADR_Z = {5'd4, 5'd31, 5'd2, 5'd1};
  localparam logic [19:0] ADR_B = {5'd8, 5'd7, 5'd6, 5'd5};

  task automatic add(input logic rst, input logic [3:0] vld, input logic [3:0] lck,
                     input logic stl, input logic [19:0] adr, input logic [3:0] rdy,
                     input logic en, input logic [4:0] wa, input logic [1:0] gid,
                     input logic bsy);
    vec_t v;
    v.rst = rst; v.vld = vld; v.lck = lck; v.stl = stl; v.adr = adr;
    v.rdy = rdy; v.en = en; v.wa = wa; v.gid = gid; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, row, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [4:0] a, input logic [1:0] id);
    return (64'(a) << 8) | (64'h10 + 64'(id));
  endfunction

  task automatic apply(input vec_t v);
    logic [4:0] a;
    reset     = v.rst;
    req_valid = v.vld;
    req_lock  = v.lck;
    wr_stall  = v.stl;
    req_addr  = v.adr;
    for (int i = 0; i < N; i++) begin
      a = v.adr[i*AW +: AW];
      req_data[i*DW +: DW] = data_of(a, 2'(i));
    end
  endtask

  initial begin
`ifdef REGFILE_ARB_FIXED_PRIO_EN
    add(1, 4'hF, 0, 0, ADR_A, 4'b0000, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    add(0, 4'hE, 0, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
`else
    // reset held two cycles, then round-robin with wrap
    add(1, 4'hF, 0, 0, ADR_A, 4'b0000, 0, 0, 0, 0);
    add(1, 4'hF, 0, 0, ADR_A, 4'b0000, 0, 0, 0, 0);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0100, 1, 3, 2, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b1000, 1, 4, 3, 1);
    add(0, 4'hF, 0, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    // zero-register beat, idle, then search resumes at 3
    add(0, 4'h4, 0, 0, ADR_Z, 4'b0100, 0, 31, 2, 0);
    add(0, 4'h0, 0, 0, ADR_Z, 4'b0000, 0, 31, 2, 0);
    add(0, 4'hF, 0, 0, ADR_B, 4'b1000, 1, 8, 3, 1);
    // stall holds a wr_addr=5 beat for 3 cycles
    add(0, 4'hF, 0, 0, ADR_B, 4'b0001, 1, 5, 0, 1);
    add(0, 4'hF, 0, 1, ADR_B, 4'b0000, 1, 5, 0, 1);
    add(0, 4'hF, 0, 1, ADR_B, 4'b0000, 1, 5, 0, 1);
    add(0, 4'hF, 0, 1, ADR_B, 4'b0000, 1, 5, 0, 1);
    add(0, 4'hF, 0, 0, ADR_B, 4'b0010, 1, 6, 1, 1);
    // lock burst by req1, forced release after 4 beats
    add(0, 4'h2, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'hB, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'hB, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'hB, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'hB, 4'h2, 0, ADR_A, 4'b1000, 1, 4, 3, 1);
    add(0, 4'hB, 4'h2, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
    // bubble while owner drops valid, then voluntary release
    add(0, 4'h2, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'h9, 4'h2, 0, ADR_A, 4'b0000, 0, 2, 1, 1);
    add(0, 4'hB, 4'h0, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(0, 4'h0, 4'h0, 0, ADR_A, 4'b0000, 0, 2, 1, 0);
    // reset mid-burst drops the lock
    add(0, 4'h2, 4'h2, 0, ADR_A, 4'b0010, 1, 2, 1, 1);
    add(1, 4'hB, 4'h2, 0, ADR_A, 4'b0000, 0, 0, 0, 0);
    add(0, 4'h9, 4'h2, 0, ADR_A, 4'b0001, 1, 1, 0, 1);
`endif

    for (int r = 0; r < vecs.size(); r++) begin
      @(negedge clk);
      apply(vecs[r]);
      #1;
      check("req_ready", r, 64'(req_ready), 64'(vecs[r].rdy));
      @(posedge clk);
      #1;
      check("wr_en", r, 64'(wr_en), 64'(vecs[r].en));
      check("wr_addr", r, 64'(wr_addr), 64'(vecs[r].wa));
      check("grant_id", r, 64'(grant_id), 64'(vecs[r].gid));
      check("busy", r, 64'(busy), 64'(vecs[r].bsy));
      check("wr_data", r, wr_data,
            (vecs[r].wa == 0 && vecs[r].gid == 0) ? 64'h0 : data_of(vecs[r].wa, vecs[r].gid));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
